// File: rtl/rggen_rtl_pkg.sv
// Shared rggen bus types: access status, access direction and the AXI4-Lite bridge state.
package rggen_rtl_pkg;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;

  typedef enum logic {
    RGGEN_READ  = 1'b0,
    RGGEN_WRITE = 1'b1
  } rggen_direction;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    BUS_ACCESS = 2'd1,
    RESPONSE   = 2'd2
  } rggen_axi4lite_bridge_state;

endpackage

// File: rtl/rggen_bus_if.sv
// Single-access register bus between the host bridge (master) and the bus splitter (slave).
interface rggen_bus_if
  import rggen_rtl_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32
);
  logic                      request;
  logic [ADDRESS_WIDTH-1:0]  address;
  rggen_direction            direction;
  logic [DATA_WIDTH-1:0]     write_data;
  logic [DATA_WIDTH/8-1:0]   write_strobe;
  logic                      done;
  logic [DATA_WIDTH-1:0]     read_data;
  rggen_status               status;

  modport master (
    output request, address, direction, write_data, write_strobe,
    input  done, read_data, status
  );

  modport slave (
    input  request, address, direction, write_data, write_strobe,
    output done, read_data, status
  );
endinterface

// File: rtl/rggen_axi4lite_bridge.sv
// AXI4-Lite slave to rggen_bus_if master, one access outstanding at a time.
// Define RGGEN_AXI4LITE_ROUND_ROBIN_EN for read/write round-robin arbitration (default: read priority).
module rggen_axi4lite_bridge
  import rggen_rtl_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32
)(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [ADDRESS_WIDTH-1:0]  awaddr,
  input  logic [2:0]                awprot,
  input  logic                      wvalid,
  output logic                      wready,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH/8-1:0]   wstrb,
  output logic                      bvalid,
  input  logic                      bready,
  output logic [1:0]                bresp,
  input  logic                      arvalid,
  output logic                      arready,
  input  logic [ADDRESS_WIDTH-1:0]  araddr,
  input  logic [2:0]                arprot,
  output logic                      rvalid,
  input  logic                      rready,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic [1:0]                rresp,
  rggen_bus_if.master               bus_if
);
  // state      | meaning
  // IDLE       | waiting for AR or AW+W; grants one per cycle
  // BUS_ACCESS | request held until splitter returns done
  // RESPONSE   | R or B valid until host accepts it
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  rggen_axi4lite_bridge_state state;
  logic                       request;
  logic [ADDRESS_WIDTH-1:0]   address;
  rggen_direction             direction;
  logic [DATA_WIDTH-1:0]      write_data;
  logic [STRB_WIDTH-1:0]      write_strobe;
  logic                       write_eligible;
  logic                       read_eligible;
  logic                       grant_read;
  logic                       grant_write;
  logic                       unused_prot;

  assign unused_prot = ^{awprot, arprot};

`ifdef RGGEN_AXI4LITE_ROUND_ROBIN_EN
  logic read_priority;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_priority <= 1'b1;
    end else if (grant_read) begin
      read_priority <= 1'b0;
    end else if (grant_write) begin
      read_priority <= 1'b1;
    end
  end
`endif

  always_comb begin
    write_eligible = awvalid && wvalid;
    read_eligible  = arvalid;
`ifdef RGGEN_AXI4LITE_ROUND_ROBIN_EN
    grant_read     = read_eligible && (!write_eligible || read_priority);
`else
    grant_read     = read_eligible;
`endif
    grant_write    = write_eligible && !grant_read;
    if (state != IDLE) begin
      grant_read  = 1'b0;
      grant_write = 1'b0;
    end
  end

  assign arready = grant_read;
  assign awready = grant_write;
  assign wready  = grant_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      request      <= 1'b0;
      address      <= '0;
      direction    <= RGGEN_READ;
      write_data   <= '0;
      write_strobe <= '0;
      rvalid       <= 1'b0;
      rdata        <= '0;
      rresp        <= '0;
      bvalid       <= 1'b0;
      bresp        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_read || grant_write) begin
            request      <= 1'b1;
            address      <= grant_read ? araddr : awaddr;
            direction    <= grant_read ? RGGEN_READ : RGGEN_WRITE;
            write_data   <= grant_read ? '0 : wdata;
            write_strobe <= grant_read ? '0 : wstrb;
            state        <= BUS_ACCESS;
          end
        end
        BUS_ACCESS: begin
          if (bus_if.done) begin
            request <= 1'b0;
            if (direction == RGGEN_READ) begin
              rvalid <= 1'b1;
              rdata  <= bus_if.read_data;
              rresp  <= bus_if.status;
            end else begin
              bvalid <= 1'b1;
              bresp  <= bus_if.status;
            end
            state <= RESPONSE;
          end
        end
        RESPONSE: begin
          // rdata/resp return to 0 so they read as 0 whenever valid is low
          if ((rvalid && rready) || (bvalid && bready)) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            rresp  <= '0;
            bvalid <= 1'b0;
            bresp  <= '0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus_if.request      = request;
  assign bus_if.address      = address;
  assign bus_if.direction    = direction;
  assign bus_if.write_data   = write_data;
  assign bus_if.write_strobe = write_strobe;

endmodule
